// File: rtl/seg7_scan_driver.sv
// ============================================================================
// seg7_scan_driver : time-multiplexed hex driver for a NUM_DIGITS 7-segment bank
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      blank_lz,
    input  logic                      disp_en,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [2:0]                digit_idx,
    output logic                      frame_done
);

    localparam int                    CNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0]      C_CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [2:0]            C_LAST_IDX = 3'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] C_AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW}};
    localparam logic [6:0]            C_SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic                  C_DP_OFF   = SEG_ACTIVE_LOW;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b0011111;
            4'hC:    s = 7'b1001110;
            4'hD:    s = 7'b0111101;
            4'hE:    s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0]          cnt_q,        cnt_d;
    logic [2:0]                idx_q,        idx_d;
    logic [4*NUM_DIGITS-1:0]   shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]     shadow_dp_q,  shadow_dp_d;
    logic                      frame_done_q, frame_done_d;
    logic [NUM_DIGITS-1:0]     an_q,         an_d;
    logic [6:0]                seg_q,        seg_d;
    logic                      dp_q,         dp_d;

    logic                      w_tick;
    logic                      w_wrap;
    logic [2:0]                w_idx_next;
    logic [4*NUM_DIGITS-1:0]   w_frame_val;
    logic [NUM_DIGITS-1:0]     w_frame_dp;
    logic [NUM_DIGITS-1:0]     w_lz;
    logic                      w_all_zero;
    logic [3:0]                w_nib;
    logic                      w_blank;
    logic                      w_dp_hi;
    logic [NUM_DIGITS-1:0]     w_an_hi;
    logic [6:0]                w_seg_hi;

    // Digit 0 of a new frame sees the value sampled on the same edge that
    // captures the shadow, so the whole frame is decoded from one snapshot.
    always_comb begin
        w_tick      = (cnt_q == C_CNT_MAX);
        w_wrap      = (idx_q == C_LAST_IDX);
        w_idx_next  = w_wrap ? 3'd0 : idx_q + 3'd1;
        w_frame_val = w_wrap ? value : shadow_val_q;
        w_frame_dp  = w_wrap ? dp_in : shadow_dp_q;

        w_lz       = '0;
        w_all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_all_zero = w_all_zero && (w_frame_val[4*i +: 4] == 4'd0);
            w_lz[i]    = w_all_zero && blank_lz && (i != 0);
        end

        w_nib   = 4'd0;
        w_blank = 1'b0;
        w_dp_hi = 1'b0;
        w_an_hi = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_idx_next == 3'(i)) begin
                w_nib      = w_frame_val[4*i +: 4];
                w_blank    = w_lz[i];
                w_dp_hi    = w_frame_dp[i];
                w_an_hi[i] = 1'b1;
            end
        end
        w_seg_hi = w_blank ? 7'd0 : hex_to_seg(w_nib);
    end

    always_comb begin
        cnt_d        = w_tick ? '0 : cnt_q + CNT_W'(1);
        idx_d        = w_tick ? w_idx_next : idx_q;
        frame_done_d = w_tick && w_wrap;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        if (w_tick && w_wrap) begin
            shadow_val_d = value;
            shadow_dp_d  = dp_in;
        end

        an_d  = an_q;
        seg_d = seg_q;
        dp_d  = dp_q;
        if (!disp_en) begin
            an_d  = C_AN_OFF;
            seg_d = C_SEG_OFF;
            dp_d  = C_DP_OFF;
        end else if (w_tick) begin
            an_d  = w_an_hi  ^ C_AN_OFF;
            seg_d = w_seg_hi ^ C_SEG_OFF;
            dp_d  = w_dp_hi  ^ C_DP_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= C_LAST_IDX;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            frame_done_q <= 1'b0;
            an_q         <= C_AN_OFF;
            seg_q        <= C_SEG_OFF;
            dp_q         <= C_DP_OFF;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            frame_done_q <= frame_done_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign digit_idx  = idx_q;
    assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// ============================================================================
// tb_seg7_scan_driver : directed and randomized checks against an edge-count model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_driver;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic        disp_en;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [2:0]  digit_idx;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    seg7_scan_driver #(
        .NUM_DIGITS     (N),
        .REFRESH_DIV    (DIV),
        .AN_ACTIVE_LOW  (1'b1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .disp_en    (disp_en),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (edges counted since reset) ----------
    function automatic logic [6:0] hex_active(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;  default: return 7'b1000111;
        endcase
    endfunction

    function automatic bit is_tick(input int e);
        return (e % DIV) == 0;
    endfunction

    function automatic int digit_at(input int e);
        return ((e / DIV) - 1) % N;
    endfunction

    function automatic logic [6:0] seg_pins(input logic [15:0] v, input int d, input logic blz);
        int msd;
        msd = 0;
        for (int i = 0; i < N; i++)
            if (v[4*i +: 4] != 4'd0) msd = i;
        if (blz && d > msd) return 7'h7F;
        return ~hex_active(v[4*d +: 4]);
    endfunction

    function automatic logic dp_pin(input logic [3:0] f, input int d);
        logic [3:0] t;
        t = f >> d;
        return ~t[0];
    endfunction

    function automatic logic [3:0] an_pin(input int d);
        return ~(4'b0001 << d);
    endfunction

    int          m_edges;
    logic [15:0] m_fval;
    logic [3:0]  m_fdp;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic [2:0]  exp_idx;
    logic        exp_fd;

    always @(posedge clk) begin
        if (rst) begin
            m_edges <= 0;
            m_fval  <= 16'h0;
            m_fdp   <= 4'h0;
            exp_an  <= 4'hF;
            exp_seg <= 7'h7F;
            exp_dp  <= 1'b1;
            exp_idx <= 3'(N - 1);
            exp_fd  <= 1'b0;
        end else begin
            m_edges <= m_edges + 1;
            exp_fd  <= is_tick(m_edges + 1) && (digit_at(m_edges + 1) == 0);
            if (is_tick(m_edges + 1)) begin
                exp_idx <= 3'(digit_at(m_edges + 1));
                if (digit_at(m_edges + 1) == 0) begin
                    m_fval <= value;
                    m_fdp  <= dp_in;
                end
            end
            if (!disp_en) begin
                exp_an  <= 4'hF;
                exp_seg <= 7'h7F;
                exp_dp  <= 1'b1;
            end else if (is_tick(m_edges + 1)) begin
                exp_an  <= an_pin(digit_at(m_edges + 1));
                exp_seg <= seg_pins((digit_at(m_edges + 1) == 0) ? value : m_fval,
                                    digit_at(m_edges + 1), blank_lz);
                exp_dp  <= dp_pin((digit_at(m_edges + 1) == 0) ? dp_in : m_fdp,
                                  digit_at(m_edges + 1));
            end
        end
    end

    // ---------------- tests ----------------
    task automatic wait_frame(output bit ok);
        @(negedge clk);
        for (int k = 0; k < 64 && frame_done !== 1'b1; k++) @(negedge clk);
        ok = (frame_done === 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1; disp_en = 1'b1; value = 16'h0; dp_in = 4'h0; blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || digit_idx !== 3'd3 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: an=%b seg=%b dp=%b idx=%0d fd=%b, required an=1111 seg=1111111 dp=1 idx=3 fd=0",
                     an, seg, dp, digit_idx, frame_done);
        end
        rst = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if (an !== 4'hF || seg !== 7'h7F || digit_idx !== 3'd3 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold edge %0d: an=%b seg=%b idx=%0d fd=%b, required an=1111 seg=1111111 idx=3 fd=0",
                         c, an, seg, digit_idx, frame_done);
            end
        end
        @(negedge clk);
        checks++;
        if (an !== 4'b1110 || seg !== 7'b0000001 || digit_idx !== 3'd0 || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL first_tick: an=%b seg=%b idx=%0d fd=%b, required an=1110 seg=0000001 idx=0 fd=1",
                     an, seg, digit_idx, frame_done);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL frame_done_width: fd=%b, required 0", frame_done);
        end
    endtask

    task automatic test_scan();
        logic [3:0] an_e [4];
        logic [6:0] seg_e [4];
        logic       dp_e [4];
        bit ok;
        an_e  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_e = '{7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111};
        dp_e  = '{1'b1, 1'b1, 1'b0, 1'b1};
        value = 16'h12AF; dp_in = 4'b0100; blank_lz = 1'b0;
        wait_frame(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL scan_sync: frame_done=0, required 1 within 64 cycles"); end
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < DIV; c++) begin
                checks++;
                if (an !== an_e[s] || seg !== seg_e[s] || dp !== dp_e[s] ||
                    frame_done !== (s == 0 && c == 0)) begin
                    errors++;
                    $display("FAIL scan slot %0d cyc %0d: an=%b seg=%b dp=%b fd=%b, required an=%b seg=%b dp=%b fd=%b",
                             s, c, an, seg, dp, frame_done, an_e[s], seg_e[s], dp_e[s], (s == 0 && c == 0));
                end
                @(negedge clk);
            end
        end
        checks++;
        if (frame_done !== 1'b1 || an !== 4'b1110) begin
            errors++;
            $display("FAIL scan_period: fd=%b an=%b after 16 cycles, required fd=1 an=1110", frame_done, an);
        end
    endtask

    task automatic test_blank();
        logic [6:0] seg_a [4];
        logic [6:0] seg_b [4];
        logic [3:0] an_e [4];
        bit ok;
        an_e  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_a = '{7'b0000001, 7'b0100100, 7'h7F, 7'h7F};
        seg_b = '{7'b0000001, 7'h7F, 7'h7F, 7'h7F};
        value = 16'h0050; dp_in = 4'h0; blank_lz = 1'b1;
        wait_frame(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL blank_sync: frame_done=0, required 1"); end
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (an !== an_e[s] || seg !== seg_a[s]) begin
                errors++;
                $display("FAIL blank_0050 digit %0d: an=%b seg=%b, required an=%b seg=%b", s, an, seg, an_e[s], seg_a[s]);
            end
            repeat (DIV) @(negedge clk);
        end
        value = 16'h0000;
        wait_frame(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL blank_sync2: frame_done=0, required 1"); end
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (an !== an_e[s] || seg !== seg_b[s]) begin
                errors++;
                $display("FAIL blank_0000 digit %0d: an=%b seg=%b, required an=%b seg=%b", s, an, seg, an_e[s], seg_b[s]);
            end
            repeat (DIV) @(negedge clk);
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_tearing();
        logic [6:0] seg_e [6];
        logic [2:0] idx_e [6];
        bit ok;
        seg_e = '{7'b0010010, 7'b1001111, 7'b1000010, 7'b0110001, 7'b1100000, 7'b0001000};
        idx_e = '{3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3};
        value = 16'h1234; dp_in = 4'h0; blank_lz = 1'b0;
        wait_frame(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL tear_sync: frame_done=0, required 1"); end
        repeat (2 * DIV) @(negedge clk);
        value = 16'hABCD;
        for (int s = 0; s < 6; s++) begin
            checks++;
            if (digit_idx !== idx_e[s] || seg !== seg_e[s]) begin
                errors++;
                $display("FAIL tearing step %0d: idx=%0d seg=%b, required idx=%0d seg=%b",
                         s, digit_idx, seg, idx_e[s], seg_e[s]);
            end
            repeat (DIV) @(negedge clk);
        end
    endtask

    task automatic test_disp_en();
        disp_en = 1'b1;
        for (int k = 0; k < 64 && digit_idx !== 3'd1; k++) @(negedge clk);
        @(negedge clk);
        disp_en = 1'b0;
        @(negedge clk);
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
            errors++;
            $display("FAIL disp_off: an=%b seg=%b dp=%b, required an=1111 seg=1111111 dp=1", an, seg, dp);
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (an !== 4'hF || digit_idx !== exp_idx) begin
                errors++;
                $display("FAIL disp_off_scan cyc %0d: an=%b idx=%0d, required an=1111 idx=%0d", c, an, digit_idx, exp_idx);
            end
        end
        disp_en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (an !== exp_an || seg !== exp_seg || dp !== exp_dp || digit_idx !== exp_idx) begin
                errors++;
                $display("FAIL disp_resume cyc %0d: an=%b seg=%b dp=%b idx=%0d, required an=%b seg=%b dp=%b idx=%0d",
                         c, an, seg, dp, digit_idx, exp_an, exp_seg, exp_dp, exp_idx);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 19) == 0) value = 16'($urandom) >> (4 * $urandom_range(0, 4));
            if ($urandom_range(0, 19) == 0) dp_in = 4'($urandom);
            if ($urandom_range(0, 29) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 39) == 0) disp_en = ~disp_en;
            @(negedge clk);
            checks++;
            if (an !== exp_an || seg !== exp_seg || dp !== exp_dp || digit_idx !== exp_idx || frame_done !== exp_fd) begin
                errors++;
                $display("FAIL random cyc %0d: an=%b seg=%b dp=%b idx=%0d fd=%b, required an=%b seg=%b dp=%b idx=%0d fd=%b",
                         c, an, seg, dp, digit_idx, frame_done, exp_an, exp_seg, exp_dp, exp_idx, exp_fd);
            end
        end
        disp_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        disp_en = 1'b1;
        for (int k = 0; k < 64 && digit_idx !== 3'd2; k++) @(negedge clk);
        checks++;
        if (digit_idx !== 3'd2) begin
            errors++;
            $display("FAIL rstmid_sync: idx=%0d, required 2", digit_idx);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || digit_idx !== 3'd3 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_state: an=%b seg=%b dp=%b idx=%0d fd=%b, required an=1111 seg=1111111 dp=1 idx=3 fd=0",
                     an, seg, dp, digit_idx, frame_done);
        end
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if (an !== ((c == 4) ? 4'b1110 : 4'hF) || an !== exp_an || digit_idx !== exp_idx) begin
                errors++;
                $display("FAIL rstmid_relight edge %0d: an=%b idx=%0d, required an=%b idx=%0d",
                         c, an, digit_idx, (c == 4) ? 4'b1110 : 4'hF, exp_idx);
            end
        end
    endtask

    initial begin
        rst = 1'b1; disp_en = 1'b1; value = 16'h0; dp_in = 4'h0; blank_lz = 1'b0;
        test_reset();
        test_scan();
        test_blank();
        test_tearing();
        test_disp_en();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
